// File: rtl/rv64g_l2_line_seq.sv
// rtl/rv64g_l2_line_seq.sv - L2 line-transfer sequencer (refill/evict), optional L2_SEQ_CRIT_WORD_EN
module rv64g_l2_line_seq #(
  parameter int WORDS = 8,
  parameter int TAG_W = 50
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     fill_req_i,
  input  logic [7:0]               fill_index_i,
  input  logic [3:0]               fill_way_i,
  input  logic [TAG_W-1:0]         fill_tag_i,
`ifdef L2_SEQ_CRIT_WORD_EN
  input  logic [$clog2(WORDS)-1:0] fill_word_i,
`endif
  output logic                     fill_gnt_o,
  input  logic                     fill_valid_i,
  input  logic [63:0]              fill_data_i,
  output logic                     fill_ready_o,
  input  logic                     evict_req_i,
  input  logic [7:0]               evict_index_i,
  input  logic [3:0]               evict_way_i,
  output logic                     evict_gnt_o,
  output logic                     evict_valid_o,
  output logic [63:0]              evict_data_o,
  output logic [TAG_W-1:0]         evict_tag_o,
  output logic                     evict_last_o,
  input  logic                     evict_ready_i,
  output logic                     done_o,
  output logic                     done_evict_o,
  output logic                     busy_o,
  output logic [7:0]               arr_index_o,
  output logic [$clog2(WORDS)-1:0] arr_word_sel_o,
  output logic [3:0]               arr_way_sel_o,
  output logic                     arr_data_we_o,
  output logic                     arr_tag_we_o,
  output logic [7:0]               arr_be_o,
  output logic [TAG_W-1:0]         arr_tag_o,
  output logic [63:0]              arr_wdata_o,
  input  logic [63:0]              arr_rdata_i,
  input  logic [TAG_W-1:0]         arr_tag_i
);

  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    FILL_TAG = 2'd2,
    EVICT    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    word_q;
  logic [CW-1:0]    start_q;
  logic [CW-1:0]    word_nxt;
  logic [CW-1:0]    fill_start;
  logic [7:0]       index_q;
  logic [3:0]       way_q;
  logic [TAG_W-1:0] tag_q;
  logic             rr_q;
  logic             beat_adv;
  logic             last_beat;

`ifdef L2_SEQ_CRIT_WORD_EN
  assign fill_start = fill_word_i;
`else
  assign fill_start = '0;
`endif

  // The line is complete when the next word would wrap back to the start word,
  // so the beat count is always WORDS whatever word the transfer began at.
  assign word_nxt  = word_q + 1'b1;
  assign last_beat = (word_nxt == start_q);

  assign busy_o        = (state_q != IDLE);
  assign arr_index_o   = index_q;
  assign arr_way_sel_o = way_q;

  // Next-state, arbitration and array/stream outputs; reset low masks everything so
  // an aborted transfer cannot issue one more write in the reset cycle.
  always_comb begin
    state_d        = state_q;
    fill_gnt_o     = 1'b0;
    evict_gnt_o    = 1'b0;
    fill_ready_o   = 1'b0;
    evict_valid_o  = 1'b0;
    evict_data_o   = '0;
    evict_tag_o    = '0;
    evict_last_o   = 1'b0;
    done_o         = 1'b0;
    done_evict_o   = 1'b0;
    arr_word_sel_o = '0;
    arr_data_we_o  = 1'b0;
    arr_tag_we_o   = 1'b0;
    arr_be_o       = '0;
    arr_tag_o      = '0;
    arr_wdata_o    = '0;
    beat_adv       = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          // rr_q=0 favours refill when both sides are waiting
          if (fill_req_i && (!evict_req_i || !rr_q)) begin
            fill_gnt_o = 1'b1;
            state_d    = FILL;
          end else if (evict_req_i) begin
            evict_gnt_o = 1'b1;
            state_d     = EVICT;
          end
        end
        FILL: begin
          fill_ready_o   = 1'b1;
          arr_word_sel_o = word_q;
          if (fill_valid_i) begin
            arr_data_we_o = 1'b1;
            arr_be_o      = 8'hFF;
            arr_wdata_o   = fill_data_i;
            beat_adv      = 1'b1;
            if (last_beat) state_d = FILL_TAG;
          end
        end
        FILL_TAG: begin
          arr_tag_we_o = 1'b1;
          arr_tag_o    = tag_q;
          done_o       = 1'b1;
          state_d      = IDLE;
        end
        EVICT: begin
          evict_valid_o  = 1'b1;
          evict_data_o   = arr_rdata_i;
          evict_tag_o    = arr_tag_i;
          evict_last_o   = last_beat;
          arr_word_sel_o = word_q;
          if (evict_ready_i) begin
            beat_adv = 1'b1;
            if (last_beat) begin
              done_o       = 1'b1;
              done_evict_o = 1'b1;
              state_d      = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, latched request arguments, word counter and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      start_q <= '0;
      index_q <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_gnt_o) begin
        index_q <= fill_index_i;
        way_q   <= fill_way_i;
        tag_q   <= fill_tag_i;
        start_q <= fill_start;
        word_q  <= fill_start;
        rr_q    <= 1'b1;
      end else if (evict_gnt_o) begin
        index_q <= evict_index_i;
        way_q   <= evict_way_i;
        start_q <= '0;
        word_q  <= '0;
        rr_q    <= 1'b0;
      end else if (beat_adv) begin
        word_q <= word_nxt;
      end
    end
  end

endmodule
